// File: rtl/prf_wb_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : prf_wb_buffer
//  Description : Writeback queue for one write requestor. Holds functional
//                unit results in FIFO order while the prf write port is
//                unavailable and presents the oldest entry to the prf.
//                Upstream stalls only when the queue is full.
//  Revision    : 1.0 - initial release
// ============================================================================
module prf_wb_buffer #(
  parameter int DEPTH           = 4,
  parameter int LOG_DEPTH       = 2,
  parameter int LOG_PR_COUNT    = 7,
  parameter int LOG_ROB_ENTRIES = 7
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [31:0]                in_data,
  input  logic [LOG_PR_COUNT-1:0]    in_PR,
  input  logic [LOG_ROB_ENTRIES-1:0] in_ROB_index,
  output logic                       in_ready,
  output logic                       WB_valid,
  output logic [31:0]                WB_data,
  output logic [LOG_PR_COUNT-1:0]    WB_PR,
  output logic [LOG_ROB_ENTRIES-1:0] WB_ROB_index,
  input  logic                       WB_ready,
  output logic [LOG_DEPTH:0]         occupancy
);

  // Pointer increment; pointers carry one extra wrap bit above the index.
  localparam logic [LOG_DEPTH:0] c_PTR_ONE = {{LOG_DEPTH{1'b0}}, 1'b1};

  logic [LOG_DEPTH:0]         r_rd_ptr;
  logic [LOG_DEPTH:0]         r_wr_ptr;

  logic [31:0]                r_data_mem [DEPTH];
  logic [LOG_PR_COUNT-1:0]    r_pr_mem   [DEPTH];
  logic [LOG_ROB_ENTRIES-1:0] r_rob_mem  [DEPTH];

  logic [LOG_DEPTH-1:0]       w_rd_idx;
  logic [LOG_DEPTH-1:0]       w_wr_idx;
  logic                       w_empty;
  logic                       w_full;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_store;

  assign w_rd_idx = r_rd_ptr[LOG_DEPTH-1:0];
  assign w_wr_idx = r_wr_ptr[LOG_DEPTH-1:0];

  // Equal pointers mean empty; same slot with opposite wrap bits means full.
  assign w_empty  = (r_rd_ptr == r_wr_ptr);
  assign w_full   = (r_rd_ptr[LOG_DEPTH-1:0] == r_wr_ptr[LOG_DEPTH-1:0]) &&
                    (r_rd_ptr[LOG_DEPTH] != r_wr_ptr[LOG_DEPTH]);

  // Ready depends on registered state only, so the prf handshake never
  // feeds back combinationally into the functional unit pipeline.
  assign in_ready = !w_full;
  assign WB_valid = !w_empty;

  assign w_push   = in_valid & !w_full;
  assign w_pop    = !w_empty & WB_ready;

  // A push that coincides with flush or reset is dropped, so skip the write.
  assign w_store  = w_push & !flush & !RST;

  assign occupancy = r_wr_ptr - r_rd_ptr;

  // Pointer update: reset beats flush, flush beats push/pop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
    end
  end

  // Entry storage; contents need no reset since the pointers gate visibility.
  always_ff @(posedge CLK) begin
    if (w_store) begin
      r_data_mem[w_wr_idx] <= in_data;
      r_pr_mem[w_wr_idx]   <= in_PR;
      r_rob_mem[w_wr_idx]  <= in_ROB_index;
    end
  end

  // Head presentation; forced to zero when empty so the prf never sees X.
  always_comb begin
    WB_data      = '0;
    WB_PR        = '0;
    WB_ROB_index = '0;
    if (!w_empty) begin
      WB_data      = r_data_mem[w_rd_idx];
      WB_PR        = r_pr_mem[w_rd_idx];
      WB_ROB_index = r_rob_mem[w_rd_idx];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prf_wb_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prf_wb_buffer
//  Description : Self-checking bench for prf_wb_buffer. A queue-based model
//                tracks the expected contents; directed scenarios add literal
//                expectations, followed by a randomized run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prf_wb_buffer;

  localparam int c_DEPTH = 4;

  typedef struct packed {
    logic [31:0] d;
    logic [6:0]  pr;
    logic [6:0]  rob;
  } ent_t;

  logic        CLK;
  logic        RST;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic [6:0]  in_PR;
  logic [6:0]  in_ROB_index;
  logic        in_ready;
  logic        WB_valid;
  logic [31:0] WB_data;
  logic [6:0]  WB_PR;
  logic [6:0]  WB_ROB_index;
  logic        WB_ready;
  logic [2:0]  occupancy;

  ent_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   check_en = 0;

  prf_wb_buffer #(
    .DEPTH(4), .LOG_DEPTH(2), .LOG_PR_COUNT(7), .LOG_ROB_ENTRIES(7)
  ) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_PR(in_PR),
    .in_ROB_index(in_ROB_index), .in_ready(in_ready),
    .WB_valid(WB_valid), .WB_data(WB_data), .WB_PR(WB_PR),
    .WB_ROB_index(WB_ROB_index), .WB_ready(WB_ready),
    .occupancy(occupancy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: reset/flush empties, pop the head if accepted, then
  // append the input if there was room at the start of the cycle.
  always @(posedge CLK) begin
    int  sz;
    ent_t e;
    sz = q.size();
    if (RST || flush) begin
      q.delete();
    end else begin
      if (sz > 0 && WB_ready) void'(q.pop_front());
      if (in_valid && sz < c_DEPTH) begin
        e.d = in_data; e.pr = in_PR; e.rob = in_ROB_index;
        q.push_back(e);
      end
    end
  end

  // Every-cycle comparison of the DUT against the model, mid-cycle.
  always @(negedge CLK) begin
    if (check_en) begin
      chk("occupancy", {29'd0, occupancy}, q.size());
      chk("in_ready",  {31'd0, in_ready},  (q.size() < c_DEPTH) ? 1 : 0);
      chk("WB_valid",  {31'd0, WB_valid},  (q.size() != 0) ? 1 : 0);
      chk("WB_data",   WB_data, (q.size() != 0) ? q[0].d : 32'd0);
      chk("WB_PR",     {25'd0, WB_PR},  (q.size() != 0) ? {25'd0, q[0].pr}  : 32'd0);
      chk("WB_ROB",    {25'd0, WB_ROB_index}, (q.size() != 0) ? {25'd0, q[0].rob} : 32'd0);
    end
  end

  // Apply one cycle of inputs, return at the following negedge.
  task automatic cyc(input logic rst, input logic fl, input logic v,
                     input logic [31:0] d, input logic [6:0] pr,
                     input logic [6:0] rob, input logic rdy);
    RST = rst; flush = fl; in_valid = v; in_data = d;
    in_PR = pr; in_ROB_index = rob; WB_ready = rdy;
    @(negedge CLK);
  endtask

  task automatic push(input logic [31:0] d, input logic rdy);
    cyc(1'b0, 1'b0, 1'b1, d, d[6:0], d[7:1], rdy);
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 7'd0, 7'd0, rdy);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_valid"}, {31'd0, WB_valid}, 32'd0);
    chk({tag, "_data"},  WB_data, 32'd0);
    chk({tag, "_occ"},   {29'd0, occupancy}, 32'd0);
  endtask

  initial begin
    RST = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    in_PR = '0; in_ROB_index = '0; WB_ready = 1'b0;

    // Scenario 1: reset state
    @(negedge CLK);
    check_en = 1;
    chk_empty("rst1");

    // Scenario 2: single entry with immediate acceptance
    cyc(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 7'h12, 7'h05, 1'b1);
    chk("s2_valid", {31'd0, WB_valid}, 32'd1);
    chk("s2_data",  WB_data, 32'hDEADBEEF);
    chk("s2_pr",    {25'd0, WB_PR}, 32'h12);
    chk("s2_rob",   {25'd0, WB_ROB_index}, 32'h05);
    idle(1'b1);
    chk("s2_valid_after", {31'd0, WB_valid}, 32'd0);
    chk("s2_occ_after",   {29'd0, occupancy}, 32'd0);

    // Scenario 3: fill while blocked, drop a fifth push, then drain in order
    for (int i = 1; i <= 4; i++) push(i, 1'b0);
    chk("s3_occ_full",   {29'd0, occupancy}, 32'd4);
    chk("s3_ready_full", {31'd0, in_ready}, 32'd0);
    push(32'd5, 1'b0);
    chk("s3_occ_drop",   {29'd0, occupancy}, 32'd4);
    for (int i = 1; i <= 4; i++) begin
      chk("s3_drain", WB_data, i);
      idle(1'b1);
    end
    chk("s3_empty", {31'd0, WB_valid}, 32'd0);

    // Scenario 4: steady push+pop at occupancy 2 across pointer wrap
    push(32'hA0, 1'b0);
    push(32'hA1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      chk("s4_head", WB_data, (k < 2) ? (32'hA0 + k) : (32'h10 + k - 2));
      push(32'h10 + k, 1'b1);
      chk("s4_occ", {29'd0, occupancy}, 32'd2);
    end
    idle(1'b1); idle(1'b1);
    chk("s4_drained", {29'd0, occupancy}, 32'd0);

    // Scenario 5: flush with a concurrent push drops everything
    for (int i = 0; i < 3; i++) push(32'h30 + i, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 32'h55, 7'h55, 7'h2A, 1'b0);
    chk("s5_occ",   {29'd0, occupancy}, 32'd0);
    chk("s5_valid", {31'd0, WB_valid}, 32'd0);
    idle(1'b0);
    chk_empty("s5_post");

    // Scenario 6: reset mid-operation, then normal use
    for (int i = 0; i < 3; i++) push(32'h40 + i, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 7'd0, 7'd0, 1'b0);
    chk_empty("s6_rst");
    push(32'h77, 1'b0);
    chk("s6_head", WB_data, 32'h77);
    chk("s6_occ",  {29'd0, occupancy}, 32'd1);

    // Randomized traffic with occasional flush and reset
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 49) == 0),
          ($urandom_range(0, 99) < 60), $urandom, 7'($urandom),
          7'($urandom), ($urandom_range(0, 99) < 45));
    end

    check_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
